// File: rtl/read_buffer_pkg.sv
// -----------------------------------------------------------------------------
// read_buffer_pkg
// Shared constants and types for the read_buffer block.
//   LINE_WIDTH  : default width of one memory line in bits
//   WORD_WIDTH  : default width of one emitted slice in bits
//   IDX_WIDTH   : width of the base/bounds/index fields
//   state_t     : IDLE / BUSY state encoding
//   clamp_bound : min(bounds, slice count) used when a line is captured
// -----------------------------------------------------------------------------
package read_buffer_pkg;

   localparam int LINE_WIDTH = 512;
   localparam int WORD_WIDTH = 64;
   localparam int IDX_WIDTH  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   // Requests past the end of the line are trimmed to the number of slices.
   function automatic logic [IDX_WIDTH-1:0] clamp_bound(
      input logic [IDX_WIDTH-1:0] bounds,
      input logic [IDX_WIDTH-1:0] n_slices
   );
      return (bounds > n_slices) ? n_slices : bounds;
   endfunction

endpackage

// File: rtl/read_buffer.sv
// -----------------------------------------------------------------------------
// read_buffer
// Captures one FULL_WIDTH memory line and streams it out WIDTH bits at a time,
// MSB-first, from slice index `base` up to (not including) `bounds`.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   rready    : a line is presented on rdata this cycle (captured on the edge)
//   rdata     : memory line, slice 0 is the top WIDTH bits
//   odata_req : consumer can take a slice this cycle
//   base      : first slice index to emit (sampled with rready)
//   bounds    : one past the last slice index to emit (sampled with rready)
//   oready    : odata holds a valid slice that is consumed this cycle
//   odata     : current slice
// -----------------------------------------------------------------------------
module read_buffer
   import read_buffer_pkg::*;
#(
   parameter int FULL_WIDTH = LINE_WIDTH,
   parameter int WIDTH      = WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rready,
   input  logic [FULL_WIDTH-1:0] rdata,
   input  logic                  odata_req,
   input  logic [IDX_WIDTH-1:0]  base,
   input  logic [IDX_WIDTH-1:0]  bounds,
   output logic                  oready,
   output logic [WIDTH-1:0]      odata
);

   // Slice count per line; assumed to fit the 8-bit index fields.
   localparam logic [IDX_WIDTH-1:0] N_SLICES  = IDX_WIDTH'(FULL_WIDTH / WIDTH);
   localparam int                   SEL_WIDTH = $clog2(FULL_WIDTH);

   state_t                r_state;
   logic [IDX_WIDTH-1:0]  r_idx;
   logic [IDX_WIDTH-1:0]  r_bound;
   logic [FULL_WIDTH-1:0] r_line;

   logic                  w_active;
   logic                  w_last;
   logic [SEL_WIDTH-1:0]  w_msb;
   logic [WIDTH-1:0]      w_slice;

   // A slice is pending only while busy and the index is still inside the range.
   assign w_active = (r_state == ST_BUSY) && (r_idx < r_bound);
   assign w_last   = (r_idx == (r_bound - 8'd1));
   assign oready   = w_active && odata_req;
   assign odata    = w_slice;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_msb   = '0;
      w_slice = '0;
      // Guard keeps the part-select inside the line once idx has run off the end.
      if (r_idx < N_SLICES) begin
         w_msb   = SEL_WIDTH'(FULL_WIDTH - 1 - int'(r_idx) * WIDTH);
         w_slice = r_line[w_msb -: WIDTH];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the wide line register is reset as well, because odata must
         // read zero after reset rather than stale data.
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_bound <= '0;
         r_line  <= '0;
      end else if (rready) begin
         // A new line always wins, dropping whatever remained of the old one.
         r_line  <= rdata;
         r_idx   <= base;
         r_bound <= clamp_bound(bounds, N_SLICES);
         r_state <= ST_BUSY;
      end else if (r_state == ST_BUSY) begin
         if (!w_active) begin
            // Empty range (bound <= base): nothing to emit.
            r_state <= ST_IDLE;
         end else if (oready) begin
            r_idx <= r_idx + 8'd1;
            if (w_last) begin
               r_state <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_read_buffer.sv
// -----------------------------------------------------------------------------
// tb_read_buffer
// Directed bench for read_buffer. Two instances share all inputs:
//   u_dut4 : FULL_WIDTH=512, WIDTH=128 (4 slices per line)
//   u_dut8 : defaults, WIDTH=64 (8 slices per line)
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
// later, well away from either clock edge.
// -----------------------------------------------------------------------------
module tb_read_buffer;

   logic         clk;
   logic         rst;
   logic         rready;
   logic [511:0] rdata;
   logic         odata_req;
   logic [7:0]   base;
   logic [7:0]   bounds;
   logic         oready4;
   logic [127:0] odata4;
   logic         oready8;
   logic [63:0]  odata8;

   int checks = 0;
   int errors = 0;

   read_buffer #(.FULL_WIDTH(512), .WIDTH(128)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .rready    (rready),
      .rdata     (rdata),
      .odata_req (odata_req),
      .base      (base),
      .bounds    (bounds),
      .oready    (oready4),
      .odata     (odata4)
   );

   read_buffer u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .rready    (rready),
      .rdata     (rdata),
      .odata_req (odata_req),
      .base      (base),
      .bounds    (bounds),
      .oready    (oready8),
      .odata     (odata8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slice k of a 64-bit-slice test line: byte {tag,k} repeated.
   function automatic logic [63:0] w8(input logic [3:0] tag, input int k);
      return {8{tag, 4'(k)}};
   endfunction

   // Slice k of a 128-bit-slice test line.
   function automatic logic [127:0] w4(input logic [3:0] tag, input int k);
      return {16{tag, 4'(k)}};
   endfunction

   function automatic logic [511:0] line8(input logic [3:0] tag);
      logic [511:0] l;
      l = '0;
      for (int k = 0; k < 8; k++) l = {l[447:0], w8(tag, k)};
      return l;
   endfunction

   function automatic logic [511:0] line4(input logic [3:0] tag);
      logic [511:0] l;
      l = '0;
      for (int k = 0; k < 4; k++) l = {l[383:0], w4(tag, k)};
      return l;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Present a line for one cycle, then drop rready and scramble base/bounds
   // (they must be ignored outside the capture cycle). Returns just after the
   // capture edge, i.e. at the start of the first emission cycle.
   task automatic start_line(input logic [511:0] line, input logic [7:0] b, input logic [7:0] bnd);
      tick();
      rready = 1'b1;
      rdata  = line;
      base   = b;
      bounds = bnd;
      tick();
      rready = 1'b0;
      base   = 8'd0;
      bounds = 8'd0;
   endtask

   int exp_idx;
   int seen;
   logic req;

   initial begin
      rst       = 1'b1;
      rready    = 1'b0;
      rdata     = '0;
      odata_req = 1'b0;
      base      = 8'd0;
      bounds    = 8'd0;

      // ---------------- reset state ----------------
      tick();
      tick();
      rst = 1'b0;
      settle();
      check("rst_oready4", 128'(oready4), 128'd0);
      check("rst_odata4",  odata4,        128'd0);
      check("rst_oready8", 128'(oready8), 128'd0);
      check("rst_odata8",  128'(odata8),  128'd0);

      // ---------------- WIDTH=128, 4 slices A..D ----------------
      tick();
      rready    = 1'b1;
      rdata     = line4(4'hC);
      base      = 8'd0;
      bounds    = 8'd4;
      odata_req = 1'b1;
      settle();
      check("w128_capture_cycle_oready", 128'(oready4), 128'd0);
      tick();
      rready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         check($sformatf("w128_oready_%0d", k), 128'(oready4), 128'd1);
         check($sformatf("w128_odata_%0d", k),  odata4,        w4(4'hC, k));
         tick();
      end
      settle();
      check("w128_idle_after", 128'(oready4), 128'd0);

      // ---------------- base=3, bounds=8 then bounds=200 ----------------
      for (int pass = 0; pass < 2; pass++) begin
         start_line(line8(4'hA), 8'd3, (pass == 0) ? 8'd8 : 8'd200);
         for (int k = 3; k < 8; k++) begin
            settle();
            check($sformatf("range_p%0d_oready_%0d", pass, k), 128'(oready8), 128'd1);
            check($sformatf("range_p%0d_odata_%0d", pass, k),  128'(odata8),  128'(w8(4'hA, k)));
            tick();
         end
         settle();
         check($sformatf("range_p%0d_done", pass), 128'(oready8), 128'd0);
      end

      // ---------------- stalls: odata_req 1,0,0,1,... ----------------
      odata_req = 1'b1;
      start_line(line8(4'hB), 8'd0, 8'd8);
      exp_idx = 0;
      seen    = 0;
      for (int c = 0; c < 18; c++) begin
         req       = ((c % 4) == 0) || ((c % 4) == 3);
         odata_req = req;
         settle();
         check($sformatf("stall_oready_c%0d", c), 128'(oready8), 128'(req && (exp_idx < 8)));
         if (req && (exp_idx < 8)) begin
            check($sformatf("stall_odata_c%0d", c), 128'(odata8), 128'(w8(4'hB, exp_idx)));
            exp_idx++;
         end
         if (oready8) seen++;
         tick();
      end
      check("stall_total_slices", 128'(seen), 128'd8);

      // ---------------- empty range, then a single slice ----------------
      odata_req = 1'b1;
      start_line(line8(4'hA), 8'd5, 8'd2);
      settle();
      check("empty_oready_c0", 128'(oready8), 128'd0);
      tick();
      settle();
      check("empty_oready_c1", 128'(oready8), 128'd0);
      start_line(line8(4'hB), 8'd0, 8'd1);
      settle();
      check("single_oready", 128'(oready8), 128'd1);
      check("single_odata",  128'(odata8),  128'(w8(4'hB, 0)));
      tick();
      settle();
      check("single_done", 128'(oready8), 128'd0);

      // ---------------- reset mid-emission ----------------
      start_line(line4(4'hD), 8'd0, 8'd4);
      settle();
      check("rstmid_odata_0", odata4, w4(4'hD, 0));
      tick();
      settle();
      check("rstmid_odata_1", odata4, w4(4'hD, 1));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check("rstmid_oready4", 128'(oready4), 128'd0);
      check("rstmid_odata4",  odata4,        128'd0);
      check("rstmid_odata8",  128'(odata8),  128'd0);
      tick();
      settle();
      check("rstmid_oready4_later", 128'(oready4), 128'd0);

      // ---------------- reset beats a simultaneous rready ----------------
      tick();
      rst    = 1'b1;
      rready = 1'b1;
      rdata  = line4(4'hE);
      base   = 8'd0;
      bounds = 8'd4;
      tick();
      rst    = 1'b0;
      rready = 1'b0;
      settle();
      check("rst_prio_oready4", 128'(oready4), 128'd0);
      check("rst_prio_odata4",  odata4,        128'd0);

      // ---------------- restart mid-line ----------------
      start_line(line8(4'hA), 8'd0, 8'd8);
      settle();
      check("restart_old_0", 128'(odata8), 128'(w8(4'hA, 0)));
      tick();
      settle();
      check("restart_old_1", 128'(odata8), 128'(w8(4'hA, 1)));
      tick();
      rready = 1'b1;
      rdata  = line8(4'h5);
      base   = 8'd2;
      bounds = 8'd5;
      settle();
      check("restart_old_2_oready", 128'(oready8), 128'd1);
      check("restart_old_2_odata",  128'(odata8),  128'(w8(4'hA, 2)));
      tick();
      rready = 1'b0;
      for (int k = 2; k < 5; k++) begin
         settle();
         check($sformatf("restart_new_oready_%0d", k), 128'(oready8), 128'd1);
         check($sformatf("restart_new_odata_%0d", k),  128'(odata8),  128'(w8(4'h5, k)));
         tick();
      end
      settle();
      check("restart_new_done", 128'(oready8), 128'd0);

      // ---------------- restart on the last emission ----------------
      start_line(line8(4'hA), 8'd6, 8'd8);
      settle();
      check("lastrs_old_6", 128'(odata8), 128'(w8(4'hA, 6)));
      tick();
      rready = 1'b1;
      rdata  = line8(4'hC);
      base   = 8'd0;
      bounds = 8'd1;
      settle();
      check("lastrs_old_7_oready", 128'(oready8), 128'd1);
      check("lastrs_old_7_odata",  128'(odata8),  128'(w8(4'hA, 7)));
      tick();
      rready = 1'b0;
      settle();
      check("lastrs_new_oready", 128'(oready8), 128'd1);
      check("lastrs_new_odata",  128'(odata8),  128'(w8(4'hC, 0)));
      tick();
      settle();
      check("lastrs_done", 128'(oready8), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
